// File: rtl/id_hazard_ctrl_pkg.sv
// Shared encodings for the decode-stage hazard controller.
package id_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

endpackage

// File: rtl/id_hazard_ctrl_hz_src_match.sv
// Per-source comparator: EX match flag and EX > MEM > WB forwarding select.
module hz_src_match
    import id_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             ex_valid_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             ex_is_load_i,
    input  logic             mem_valid_i,
    input  logic [REG_W-1:0] mem_rd_i,
    input  logic             wb_valid_i,
    input  logic [REG_W-1:0] wb_rd_i,
    input  logic [REG_W-1:0] rs_i,
    input  logic             use_i,
    output logic             ex_match_o,
    output fwd_sel_e         sel_o
);

    logic active;
    logic mem_match;
    logic wb_match;

    // x0 and unused sources never match anything
    assign active     = use_i && (rs_i != '0);
    assign ex_match_o = active && ex_valid_i  && (rs_i == ex_rd_i);
    assign mem_match  = active && mem_valid_i && (rs_i == mem_rd_i);
    assign wb_match   = active && wb_valid_i  && (rs_i == wb_rd_i);

    always_comb begin
        sel_o = FWD_RF;
        if (ex_match_o && !ex_is_load_i) begin
            sel_o = FWD_EX;
        end else if (mem_match) begin
            sel_o = FWD_MEM;
        end else if (wb_match) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard controller: tracks EX/MEM/WB destinations and drives
// stall, bubble, flush and forwarding selects for the ID stage.
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic             id_we_i,
    input  logic             id_is_load_i,
    input  logic             ex_flush_i,
    input  logic             ext_stall_i,
    output logic             stall_if_o,
    output logic             stall_id_o,
    output logic             bubble_ex_o,
    output logic             flush_if_o,
    output logic             flush_id_o,
    output logic [1:0]       fwd_sel1_o,
    output logic [1:0]       fwd_sel2_o,
    output logic [CNT_W-1:0] stall_count_o
);

    logic             ex_valid_q,  ex_valid_d;
    logic [REG_W-1:0] ex_rd_q,     ex_rd_d;
    logic             ex_ld_q,     ex_ld_d;
    logic             mem_valid_q, mem_valid_d;
    logic [REG_W-1:0] mem_rd_q,    mem_rd_d;
    logic             wb_valid_q,  wb_valid_d;
    logic [REG_W-1:0] wb_rd_q,     wb_rd_d;
    logic [CNT_W-1:0] count_q,     count_d;

    logic     ex_match1, ex_match2;
    fwd_sel_e sel1, sel2;
    logic     lu;

    hz_src_match #(.REG_W(REG_W)) u_match_rs1 (
        .ex_valid_i  (ex_valid_q),
        .ex_rd_i     (ex_rd_q),
        .ex_is_load_i(ex_ld_q),
        .mem_valid_i (mem_valid_q),
        .mem_rd_i    (mem_rd_q),
        .wb_valid_i  (wb_valid_q),
        .wb_rd_i     (wb_rd_q),
        .rs_i        (id_rs1_i),
        .use_i       (id_use_rs1_i),
        .ex_match_o  (ex_match1),
        .sel_o       (sel1)
    );

    hz_src_match #(.REG_W(REG_W)) u_match_rs2 (
        .ex_valid_i  (ex_valid_q),
        .ex_rd_i     (ex_rd_q),
        .ex_is_load_i(ex_ld_q),
        .mem_valid_i (mem_valid_q),
        .mem_rd_i    (mem_rd_q),
        .wb_valid_i  (wb_valid_q),
        .wb_rd_i     (wb_rd_q),
        .rs_i        (id_rs2_i),
        .use_i       (id_use_rs2_i),
        .ex_match_o  (ex_match2),
        .sel_o       (sel2)
    );

    assign lu         = id_valid_i && ex_ld_q && (ex_match1 || ex_match2);
    assign fwd_sel1_o = sel1;
    assign fwd_sel2_o = sel2;
    assign stall_count_o = count_q;

    // ext_stall > ex_flush > load-use
    always_comb begin
        stall_if_o  = 1'b0;
        stall_id_o  = 1'b0;
        bubble_ex_o = 1'b0;
        flush_if_o  = 1'b0;
        flush_id_o  = 1'b0;
        count_d     = count_q;
        if (ext_stall_i) begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
        end else if (ex_flush_i) begin
            flush_if_o  = 1'b1;
            flush_id_o  = 1'b1;
            bubble_ex_o = 1'b1;
        end else if (lu) begin
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            bubble_ex_o = 1'b1;
            if (count_q != {CNT_W{1'b1}}) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_rd_d     = ex_rd_q;
        ex_ld_d     = ex_ld_q;
        mem_valid_d = mem_valid_q;
        mem_rd_d    = mem_rd_q;
        wb_valid_d  = wb_valid_q;
        wb_rd_d     = wb_rd_q;
        if (!ext_stall_i) begin
            wb_valid_d  = mem_valid_q;
            wb_rd_d     = mem_rd_q;
            mem_valid_d = ex_valid_q;
            mem_rd_d    = ex_rd_q;
            // x0 and non-writing instructions are stored as empty slots
            ex_valid_d  = id_valid_i && !bubble_ex_o && id_we_i && (id_rd_i != '0);
            ex_rd_d     = id_rd_i;
            ex_ld_d     = id_is_load_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= '0;
            ex_ld_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            count_q     <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            ex_ld_q     <= ex_ld_d;
            mem_valid_q <= mem_valid_d;
            mem_rd_q    <= mem_rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            count_q     <= count_d;
        end
    end

endmodule
